// File: rtl/randomness_scheduler_pkg.sv
// randomness_scheduler_pkg: shared constants and sizing helpers for the randomness scheduler
package randomness_scheduler_pkg;

    localparam int RAND_STALL_COUNT_WIDTH = 16;

    // Fresh random elements a share-zero generator consumes per use; 0 marks an unsupported share count
    function automatic int num_zero_randoms(input int shares);
        return shares == 2 ? 1 : shares == 3 ? 2 : (shares == 4 || shares == 5) ? shares : 0;
    endfunction

    // Width of one random word; never collapses to zero so illegal configs still elaborate far enough to report
    function automatic int rand_word_width(input int shares, input int bit_width);
        return (num_zero_randoms(shares) > 0 ? num_zero_randoms(shares) : 1) * bit_width;
    endfunction

endpackage

// File: rtl/randomness_scheduler_rr_arbiter.sv
// randomness_scheduler_rr_arbiter: round-robin arbiter, priority starts one above the last winner
module randomness_scheduler_rr_arbiter #(
    parameter int N = 4,
    localparam int IW = N > 1 ? $clog2(N) : 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] req_i,
    input  logic         en_i,
    output logic [N-1:0] gnt_o
);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  rot;

    assign rot = N'({req_i, req_i} >> ptr_q);

    // Scan the rotated request vector from the top down so the lowest offset from the pointer wins
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        for (int k = N - 1; k >= 0; k--)
            if (rot[k]) begin
                gnt_o = N'(1) << IW'((int'(ptr_q) + k) % N);
                ptr_d = IW'((int'(ptr_q) + k + 1) % N);
            end
    end

    // Pointer moves past the winner only when a grant is actually taken
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) ptr_q <= '0;
        else if (en_i && |req_i) ptr_q <= ptr_d;

endmodule

// File: rtl/randomness_scheduler.sv
// randomness_scheduler: FIFO-buffered single-use randomness handed round-robin to masked gadgets; RANDOMNESS_SCHEDULER_STALL_COUNT_EN adds a starvation cycle counter
module randomness_scheduler
    import randomness_scheduler_pkg::*;
#(
    parameter int NUM_SHARES     = 2,
    parameter int BIT_WIDTH      = 8,
    parameter int NUM_REQUESTERS = 4,
    parameter int FIFO_DEPTH     = 4,
    localparam int NUM_NEEDED    = num_zero_randoms(NUM_SHARES),
    localparam int WORD_W        = rand_word_width(NUM_SHARES, BIT_WIDTH),
    localparam int PTR_W         = $clog2(FIFO_DEPTH),
    localparam int LVL_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                      in_clock,
    input  logic                      in_reset,
    input  logic                      in_rand_valid,
    input  logic [WORD_W-1:0]         in_rand_data,
    output logic                      out_rand_ready,
    input  logic [NUM_REQUESTERS-1:0] in_req,
    output logic [NUM_REQUESTERS-1:0] out_grant,
    output logic [WORD_W-1:0]         out_random,
    output logic                      out_starved,
    output logic [LVL_W-1:0]          out_level
`ifdef RANDOMNESS_SCHEDULER_STALL_COUNT_EN
    ,
    output logic [RAND_STALL_COUNT_WIDTH-1:0] out_stall_count
`endif
);

    if (NUM_NEEDED == 0 || NUM_REQUESTERS < 1 || NUM_REQUESTERS > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16
        || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("randomness_scheduler: unsupported parameter set");
    end

    logic [WORD_W-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]          level_q, level_d;
    logic [NUM_REQUESTERS-1:0] grant_q, grant_d, req_eff, winner;
    logic [WORD_W-1:0]         random_q, random_d;
    logic                      starved_q, starved_d, push, pop;

    // A slot still requesting while its grant is visible has not consumed it yet, so it sits out this cycle
    assign req_eff        = in_req & ~grant_q;
    assign out_rand_ready = in_reset && level_q < LVL_W'(FIFO_DEPTH);
    assign push           = in_rand_valid && out_rand_ready;
    assign pop            = |req_eff && level_q != '0;
    assign out_grant      = grant_q;
    assign out_random     = random_q;
    assign out_starved    = starved_q;
    assign out_level      = level_q;

    randomness_scheduler_rr_arbiter #(.N(NUM_REQUESTERS)) u_arb (
        .clk_i (in_clock),
        .rst_ni(in_reset),
        .req_i (req_eff),
        .en_i  (pop),
        .gnt_o (winner)
    );

    // Next-state for pointers, occupancy and the registered grant/word outputs
    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d   = level_q + LVL_W'(push) - LVL_W'(pop);
        grant_d   = pop ? winner : '0;
        random_d  = pop ? mem_q[rd_ptr_q] : random_q;
        starved_d = |in_req && level_q == '0;
    end

    // Control state; reset discards buffered words and cancels any pending grant
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            grant_q   <= '0;
            random_q  <= '0;
            starved_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            grant_q   <= grant_d;
            random_q  <= random_d;
            starved_q <= starved_d;
        end
    end

    // Storage needs no reset: a word is only readable once occupancy covers it
    always_ff @(posedge in_clock)
        if (push) mem_q[wr_ptr_q] <= in_rand_data;

`ifdef RANDOMNESS_SCHEDULER_STALL_COUNT_EN
    logic [RAND_STALL_COUNT_WIDTH-1:0] stall_q;

    assign out_stall_count = stall_q;

    // Saturating count of starved cycles
    always_ff @(posedge in_clock or negedge in_reset)
        if (!in_reset) stall_q <= '0;
        else if (starved_q && !(&stall_q)) stall_q <= stall_q + 1'b1;
`endif

endmodule

// File: doc/randomness_scheduler.md
Name: randomness_scheduler

Overview:
- Buffers fresh randomness words from an external PRNG/TRNG source in a small FIFO.
- Hands each word to exactly one of NUM_REQUESTERS masked-gadget slots, each feeding a share-zero generator, using round-robin arbitration.
- Sits between the design's randomness source and the zero-sharing/refresh stages of the masked AES datapath.
- Guarantees no randomness word is ever delivered twice.

Parameters:
- NUM_SHARES, 2: masking order + 1. Determines NUM_NEEDED (1 for 2 shares, 2 for 3, NUM_SHARES for 4 or 5; other values are an elaboration error).
- BIT_WIDTH, 8: width of one random element.
- NUM_REQUESTERS, 4: number of consumer slots, range 1..8.
- FIFO_DEPTH, 4: buffered words; power of two, range 2..16.

Ports:
- in_clock  input  1  system clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_rand_valid  input  1  source offers a word.
- in_rand_data  input  NUM_NEEDED*BIT_WIDTH  random word (NUM_NEEDED elements of BIT_WIDTH).
- out_rand_ready  output  1  scheduler accepts the word this cycle.
- in_req  input  NUM_REQUESTERS  per-slot request; level, held until granted.
- out_grant  output  NUM_REQUESTERS  one-hot grant, registered, one-cycle pulse.
- out_random  output  NUM_NEEDED*BIT_WIDTH  word for the granted slot; valid when out_grant != 0.
- out_starved  output  1  registered: at least one request pending while FIFO is empty.
- out_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (in_reset = 0, asynchronous): FIFO flushed, level 0, read/write pointers 0, round-robin pointer 0, out_grant 0, out_random 0, out_starved 0. out_rand_ready is 0 while reset is asserted.
- Push: out_rand_ready = (level < FIFO_DEPTH). Push occurs when in_rand_valid && out_rand_ready. There is no bypass: a word pushed in cycle t is poppable at the earliest in cycle t+1.
- Pop/grant: in cycle t, if |in_req and level > 0:
  - the arbiter selects a winner;
  - head word pops;
  - at edge t+1, out_grant = onehot(winner) and out_random = head word.
- Grant latency is 1 cycle. out_grant is 0 in every cycle following a non-pop cycle. out_random holds its last value when there is no grant; it is not cleared.
- Requester handshake: a requester must deassert in_req in the cycle out_grant is seen. A request still asserted in that cycle is treated as a new request; no pop happens in that cycle for that slot.
- Arbitration: round-robin, searching upward from (last_winner+1) mod NUM_REQUESTERS, with wrap-around. The pointer updates only on a grant. After reset, slot 0 has the highest priority.
- Simultaneous push and pop:
  - allowed in any cycle, level unchanged;
  - at level == FIFO_DEPTH, ready is 0, so a push is impossible even if a pop happens the same cycle;
  - at level 0 a pop is impossible, even with a push that cycle.
- out_starved(t+1) = |in_req(t) && level(t) == 0.
- Pointers wrap modulo FIFO_DEPTH; level never exceeds FIFO_DEPTH or goes below 0.
- Single-use rule: every accepted word appears on out_random exactly once, in acceptance order. Words dropped by reset are never emitted.
- Reset mid-operation: any pending pop and grant are cancelled and buffered words are discarded.

Optional Feature:
- Macro: RANDOMNESS_SCHEDULER_STALL_COUNT_EN.
- Defined:
  - adds output out_stall_count, 16 bits, reset 0;
  - increments on every cycle where out_starved is 1 and saturates at 16'hFFFF;
  - intended for throughput characterisation.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- aes128_package gains:
  - function num_zero_randoms(int shares), returning NUM_NEEDED per the rule above;
  - a parameterised random-word typedef helper;
  - constant RAND_STALL_COUNT_WIDTH = 16.
- Sub-module rr_arbiter (parameter N): inputs req[N], en; outputs one-hot gnt[N]. Holds the round-robin pointer, which advances when en && |req.
- The FIFO storage stays in randomness_scheduler. Output registers reuse the existing register module.

Test Plan:
- Reset then push 4 words (NUM_SHARES=2, BIT_WIDTH=8) 8'hA1, 8'hB2, 8'hC3, 8'hD4 with no requests -> level 4, out_rand_ready 0, fifth valid word 8'hE5 not accepted.
- From full, assert in_req = 4'b1111 held, each slot dropping its request on its grant -> grants 0001, 0010, 0100, 1000 on 4 consecutive cycles with out_random A1, B2, C3, D4; level 0.
- Empty FIFO, in_req = 4'b0100 -> out_starved 1 next cycle, no grant. Then push 8'h5A -> grant 0100 with out_random 8'h5A two cycles after the push; out_starved drops.
- Continuous push and request at level 2 -> level stays 2 every cycle; output order equals input order; no word is emitted twice (scoreboard).
- Assert in_reset = 0 mid-stream at level 3 with a request pending -> out_grant 0 and level 0 immediately (asynchronous); after release, out_rand_ready 1 and the first grant goes to slot 0.
- With RANDOMNESS_SCHEDULER_STALL_COUNT_EN defined, hold a request for 10 cycles with the FIFO empty -> out_stall_count == 10.
